// File: rtl/pt_block_fifo.sv
// Plaintext block FIFO tagging each 128-bit block with a CTR-mode counter; FWFT head view, 1-cycle push-to-valid.
// Pushes are dropped while full unless a pop occurs in the same cycle; overflow_error pulses the cycle after a drop.
module pt_block_fifo #(
   parameter int DEPTH = 4,
   parameter int CTR_W = 32
) (
   input  logic                       HCLK,
   input  logic                       HRESETn,
   input  logic                       write_out,
   input  logic [127:0]               plain_text,
   input  logic                       ctr_clear,
   input  logic                       blk_ready,
   output logic                       fifo_full,
   output logic                       fifo_empty,
   output logic                       blk_valid,
   output logic [127:0]               blk_data,
   output logic [CTR_W-1:0]           blk_ctr,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow_error
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [127:0]     data_mem [DEPTH];
   logic [CTR_W-1:0] tag_mem  [DEPTH];

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [CTR_W-1:0] ctr_q, ctr_d;
   logic             ovf_q, ovf_d;

   logic             push, pop;
   logic [CTR_W-1:0] tag_w;

   assign fifo_full  = (count_q == CW'(DEPTH));
   assign fifo_empty = (count_q == '0);
   assign blk_valid  = ~fifo_empty;
   assign blk_data   = data_mem[rd_ptr_q];
   assign blk_ctr    = tag_mem[rd_ptr_q];
   assign count      = count_q;
   assign overflow_error = ovf_q;

   // A pop frees the slot the same cycle, so a full FIFO can still accept a push alongside it.
   assign pop   = blk_valid & blk_ready;
   assign push  = write_out & (~fifo_full | pop);
   assign tag_w = ctr_clear ? '0 : ctr_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ctr_d    = ctr_clear ? '0 : ctr_q;
      ovf_d    = write_out & ~push;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
         ctr_d    = tag_w + CTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ctr_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ctr_q    <= ctr_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage carries no reset; entries are only observable through a valid head.
   always_ff @(posedge HCLK) begin
      if (push) begin
         data_mem[wr_ptr_q] <= plain_text;
         tag_mem[wr_ptr_q]  <= tag_w;
      end
   end

endmodule
